qupls4_agen_tlb: RTL and testbench



---
 rtl/qupls4_agen_tlb.sv | 180 ++++++++++++++++++
 tb/tb_qupls4_agen_tlb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/qupls4_agen_tlb.sv
// Data TLB behind the agen: accepts the sticky vadr, translates it, and walks the page table on a miss.
// Latency: hit -> tlb_v one cycle after acceptance; miss -> tlb_v one cycle after the walk_ack edge.
// Backpressure: requests are taken only in IDLE; the tlb_v pulse is what releases the agen's sticky valid.
module qupls4_agen_tlb #(
  parameter int NENT      = 8,
  parameter int PAGE_BITS = 12,
  parameter int ADDR_W    = 64,
  parameter int ASID_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [ASID_W-1:0]           asid,
  input  logic [ADDR_W-1:0]           agen_res,
  input  logic                        agen_resv,
  input  logic                        agen_store,
  output logic                        tlb_v,
  output logic [ADDR_W-1:0]           tlb_padr,
  output logic                        tlb_fault,
  output logic                        walk_req,
  output logic [ADDR_W-1:0]           walk_vadr,
  output logic [ASID_W-1:0]           walk_asid,
  input  logic                        walk_ack,
  input  logic [ADDR_W-PAGE_BITS-1:0] walk_ppn,
  input  logic                        walk_pv,
  input  logic                        walk_pr,
  input  logic                        walk_pw,
  output logic [31:0]                 miss_cnt
);

  localparam int IDX_W = $clog2(NENT);
  localparam int VPN_W = ADDR_W - PAGE_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_WALK, ST_RESP} state_t;

  typedef struct packed {
    logic              v;
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  ppn;
    logic              r;
    logic              w;
  } tlb_ent_t;

  state_t             state_q, state_d;
  tlb_ent_t           ent_q [NENT];
  logic [IDX_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]  vadr_q;
  logic [ASID_W-1:0]  asid_q;
  logic               store_q;
  logic               discard_q;
  logic               tlb_v_q, tlb_fault_q, walk_req_q;
  logic [ADDR_W-1:0]  tlb_padr_q, walk_vadr_q;
  logic [ASID_W-1:0]  walk_asid_q;
  logic [31:0]        miss_cnt_q;

  logic               accept;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               fill_en;
  tlb_ent_t           hit_ent;

  // Associative compare; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (ent_q[i].v && ent_q[i].vpn == vadr_q[ADDR_W-1:PAGE_BITS] && ent_q[i].asid == asid_q) begin
        hit     = 1'b1;
        hit_idx = i[IDX_W-1:0];
      end
    end
    hit_ent = ent_q[hit_idx];
  end

  // A walk result is written back only if no flush has hit this walk, including on the ack edge itself.
  assign fill_en = (state_q == ST_WALK) && walk_ack && walk_pv && !discard_q && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; agen_resv outside IDLE and walk_ack outside WALK are don't-cares.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (agen_resv) begin
          accept  = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = hit ? ST_RESP : ST_WALK;
      ST_WALK:   if (walk_ack) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // TLB array: flush clears valid bits only; fills go round-robin through ptr_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NENT; i++) ent_q[i] <= '0;
      ptr_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < NENT; i++) ent_q[i].v <= 1'b0;
    end else if (fill_en) begin
      ent_q[ptr_q] <= '{v: 1'b1, vpn: vadr_q[ADDR_W-1:PAGE_BITS], asid: asid_q,
                        ppn: walk_ppn, r: walk_pr, w: walk_pw};
      ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  // Request capture, walk handshake, response pulse and miss counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vadr_q      <= '0;
      asid_q      <= '0;
      store_q     <= 1'b0;
      discard_q   <= 1'b0;
      tlb_v_q     <= 1'b0;
      tlb_fault_q <= 1'b0;
      tlb_padr_q  <= '0;
      walk_req_q  <= 1'b0;
      walk_vadr_q <= '0;
      walk_asid_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      tlb_v_q     <= 1'b0;
      tlb_fault_q <= 1'b0;
      tlb_padr_q  <= '0;
      if (accept) begin
        vadr_q  <= agen_res;
        asid_q  <= asid;
        store_q <= agen_store;
      end
      if (state_q == ST_IDLE)                discard_q <= 1'b0;
      else if (state_q == ST_WALK && flush)  discard_q <= 1'b1;
      case (state_q)
        ST_LOOKUP: begin
          if (hit) begin
            tlb_v_q     <= 1'b1;
            tlb_padr_q  <= {hit_ent.ppn, vadr_q[PAGE_BITS-1:0]};
            tlb_fault_q <= store_q ? ~hit_ent.w : ~hit_ent.r;
          end else begin
            walk_req_q  <= 1'b1;
            walk_vadr_q <= vadr_q;
            walk_asid_q <= asid_q;
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
        ST_WALK: begin
          if (walk_ack) begin
            walk_req_q <= 1'b0;
            tlb_v_q    <= 1'b1;
            if (walk_pv) begin
              tlb_padr_q  <= {walk_ppn, vadr_q[PAGE_BITS-1:0]};
              tlb_fault_q <= store_q ? ~walk_pw : ~walk_pr;
            end else begin
              tlb_fault_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tlb_v     = tlb_v_q;
  assign tlb_padr  = tlb_padr_q;
  assign tlb_fault = tlb_fault_q;
  assign walk_req  = walk_req_q;
  assign walk_vadr = walk_vadr_q;
  assign walk_asid = walk_asid_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_qupls4_agen_tlb.sv
// Directed bench for qupls4_agen_tlb: cold miss, hit, permission fault, invalid PTE,
// flush during walk, reset mid-walk, replacement wrap.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_qupls4_agen_tlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] asid;
  logic [63:0] agen_res;
  logic        agen_resv;
  logic        agen_store;
  logic        tlb_v;
  logic [63:0] tlb_padr;
  logic        tlb_fault;
  logic        walk_req;
  logic [63:0] walk_vadr;
  logic [15:0] walk_asid;
  logic        walk_ack;
  logic [51:0] walk_ppn;
  logic        walk_pv, walk_pr, walk_pw;
  logic [31:0] miss_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qupls4_agen_tlb #(.NENT(8), .PAGE_BITS(12), .ADDR_W(64), .ASID_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .asid(asid),
    .agen_res(agen_res), .agen_resv(agen_resv), .agen_store(agen_store),
    .tlb_v(tlb_v), .tlb_padr(tlb_padr), .tlb_fault(tlb_fault),
    .walk_req(walk_req), .walk_vadr(walk_vadr), .walk_asid(walk_asid),
    .walk_ack(walk_ack), .walk_ppn(walk_ppn), .walk_pv(walk_pv),
    .walk_pr(walk_pr), .walk_pw(walk_pw), .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request; returns just after the acceptance edge E0.
  task automatic accept(input logic [63:0] va, input logic st);
    @(posedge clk); #1;
    agen_res   = va;
    agen_store = st;
    agen_resv  = 1'b1;
    @(posedge clk); #1;
    agen_resv  = 1'b0;
  endtask

  // From just after E0: expects a hit response after E1.
  task automatic expect_hit(input string tag, input logic [63:0] padr, input logic fault);
    @(negedge clk);
    check({tag, "_lookup_v"}, 64'(tlb_v), 64'd0);
    @(negedge clk);
    check({tag, "_v"}, 64'(tlb_v), 64'd1);
    check({tag, "_padr"}, tlb_padr, padr);
    check({tag, "_fault"}, 64'(tlb_fault), 64'(fault));
    check({tag, "_nowalk"}, 64'(walk_req), 64'd0);
    @(negedge clk);
    check({tag, "_v_drop"}, 64'(tlb_v), 64'd0);
    check({tag, "_padr_clr"}, tlb_padr, 64'd0);
  endtask

  // From just after E0: expects a miss, ending at the first negedge with walk_req high.
  task automatic walk_start(input string tag);
    @(negedge clk);
    check({tag, "_lookup_req"}, 64'(walk_req), 64'd0);
    @(negedge clk);
    check({tag, "_req"}, 64'(walk_req), 64'd1);
    check({tag, "_req_v"}, 64'(tlb_v), 64'd0);
  endtask

  // Returns the walk result and checks the response pulse on the next cycle.
  task automatic walk_finish(input string tag, input logic [51:0] ppn, input logic pv,
                             input logic pr, input logic pw,
                             input logic [63:0] padr, input logic fault);
    walk_ack = 1'b1;
    walk_ppn = ppn;
    walk_pv  = pv;
    walk_pr  = pr;
    walk_pw  = pw;
    @(posedge clk); #1;
    walk_ack = 1'b0;
    @(negedge clk);
    check({tag, "_v"}, 64'(tlb_v), 64'd1);
    check({tag, "_padr"}, tlb_padr, padr);
    check({tag, "_fault"}, 64'(tlb_fault), 64'(fault));
    check({tag, "_req_drop"}, 64'(walk_req), 64'd0);
    @(negedge clk);
    check({tag, "_v_drop"}, 64'(tlb_v), 64'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; asid = 16'd1;
    agen_res = '0; agen_resv = 1'b0; agen_store = 1'b0;
    walk_ack = 1'b0; walk_ppn = '0; walk_pv = 1'b0; walk_pr = 1'b0; walk_pw = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tlb_v", 64'(tlb_v), 64'd0);
    check("rst_fault", 64'(tlb_fault), 64'd0);
    check("rst_padr", tlb_padr, 64'd0);
    check("rst_walk_req", 64'(walk_req), 64'd0);
    check("rst_walk_vadr", walk_vadr, 64'd0);
    check("rst_walk_asid", 64'(walk_asid), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Cold miss: walk_req held three cycles, then the PTE comes back (read-only page)
    accept(64'h0000_0000_1234_5678, 1'b0);
    walk_start("cold");
    check("cold_walk_vadr", walk_vadr, 64'h1234_5678);
    check("cold_walk_asid", 64'(walk_asid), 64'd1);
    @(negedge clk);
    check("cold_req_2", 64'(walk_req), 64'd1);
    @(negedge clk);
    check("cold_req_3", 64'(walk_req), 64'd1);
    walk_finish("cold", 52'hABCDE, 1'b1, 1'b1, 1'b0, 64'hABCD_E678, 1'b0);
    check("cold_miss_cnt", 64'(miss_cnt), 64'd1);

    // Hit on the same address
    accept(64'h0000_0000_1234_5678, 1'b0);
    expect_hit("hit", 64'hABCD_E678, 1'b0);
    check("hit_miss_cnt", 64'(miss_cnt), 64'd1);

    // Store to the read-only page
    accept(64'h0000_0000_1234_59AB, 1'b1);
    expect_hit("perm", 64'hABCD_E9AB, 1'b1);

    // Invalid PTE: fault with zero address, no fill, so the page misses again
    accept(64'h0000_0000_5555_5000, 1'b0);
    walk_start("inv1");
    walk_finish("inv1", 52'h99999, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1);
    accept(64'h0000_0000_5555_5000, 1'b0);
    walk_start("inv2");
    walk_finish("inv2", 52'h99999, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1);
    check("inv_miss_cnt", 64'(miss_cnt), 64'd3);

    // Flush during WALK: response still delivered, fill discarded, earlier entries gone
    accept(64'h0000_0000_6666_6ABC, 1'b0);
    walk_start("fl");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    walk_finish("fl", 52'h11111, 1'b1, 1'b1, 1'b1, 64'h1111_1ABC, 1'b0);
    accept(64'h0000_0000_6666_6ABC, 1'b0);
    walk_start("fl_again");
    check("fl_miss_cnt", 64'(miss_cnt), 64'd5);
    walk_finish("fl_again", 52'h22222, 1'b1, 1'b1, 1'b1, 64'h2222_2ABC, 1'b0);
    accept(64'h0000_0000_1234_5678, 1'b0);
    walk_start("fl_old");
    walk_finish("fl_old", 52'hABCDE, 1'b1, 1'b1, 1'b0, 64'hABCD_E678, 1'b0);
    check("fl_old_miss_cnt", 64'(miss_cnt), 64'd6);

    // Reset mid-walk, then a stray walk_ack must not produce a response
    accept(64'h0000_0000_7777_7000, 1'b0);
    walk_start("rstw");
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_req", 64'(walk_req), 64'd0);
    check("rstw_vadr", walk_vadr, 64'd0);
    check("rstw_miss_cnt", 64'(miss_cnt), 64'd0);
    check("rstw_v", 64'(tlb_v), 64'd0);
    walk_ack = 1'b1; walk_pv = 1'b1; walk_ppn = 52'h33333;
    @(posedge clk); #1;
    walk_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_ack_v", 64'(tlb_v), 64'd0);
    end

    // Replacement wrap: pages 1..9 fill entries 0..7 then entry 0 again
    for (int i = 0; i < 9; i++) begin
      logic [51:0] p;
      logic [63:0] va;
      p  = 52'h800 + 52'(i);
      va = (64'(i + 1) << 12) | 64'h010;
      accept(va, 1'b0);
      walk_start("wrap");
      walk_finish("wrap", p, 1'b1, 1'b1, 1'b1, {p, 12'h010}, 1'b0);
    end
    check("wrap_miss_cnt", 64'(miss_cnt), 64'd9);
    accept(64'h0000_0000_0000_9010, 1'b0);
    expect_hit("wrap_p9", 64'h0000_0000_0080_8010, 1'b0);
    accept(64'h0000_0000_0000_2010, 1'b0);
    expect_hit("wrap_p2", 64'h0000_0000_0080_1010, 1'b0);
    accept(64'h0000_0000_0000_1010, 1'b0);
    walk_start("wrap_p1");
    walk_finish("wrap_p1", 52'h800, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0080_0010, 1'b0);
    check("wrap_final_miss_cnt", 64'(miss_cnt), 64'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
